// File: rtl/gates_checker.sv
// Response checker for the two-input gate bank: compares observed gate outputs
// against golden values, counts errors, tracks input coverage and reports pass.
module gates_checker #(
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and1,
  input  logic             nand1,
  input  logic             or1,
  input  logic             nor1,
  input  logic             xor1,
  input  logic             xnor1,
  input  logic             not1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] vec_cnt,
  output logic [3:0]       cov,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic          s1_vld, s1_a, s1_b;
  logic [6:0]    s1_obs;
  logic [6:0]    gold, mask;
  logic [3:0]    cov_nxt;
  logic          cmp_fail, covered, expire;
  logic [TW-1:0] run_cnt;

  // Stage 2: golden compare on the registered vector.
  always_comb begin
    gold     = {s1_a & s1_b, ~(s1_a & s1_b), s1_a | s1_b, ~(s1_a | s1_b),
                s1_a ^ s1_b, ~(s1_a ^ s1_b), ~s1_a};
    mask     = gold ^ s1_obs;
    cmp_fail = s1_vld & (|mask);
    cov_nxt  = cov | (s1_vld ? 4'(4'b0001 << {s1_a, s1_b}) : 4'b0000);
    covered  = s1_vld && (cov_nxt == 4'b1111);
    expire   = (run_cnt == TW'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (covered || expire) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done & ~(|err_cnt) & ~timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      s1_vld          <= 1'b0;
      s1_a            <= 1'b0;
      s1_b            <= 1'b0;
      s1_obs          <= '0;
      run_cnt         <= '0;
      timeout         <= 1'b0;
      mismatch        <= 1'b0;
      err_cnt         <= '0;
      vec_cnt         <= '0;
      cov             <= '0;
      first_fail_vld  <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      state  <= state_nxt;
      // A vector only enters stage 1 if the run continues past this edge.
      s1_vld <= in_valid && (state == RUN) && !start && (state_nxt == RUN);
      s1_a   <= a;
      s1_b   <= b;
      s1_obs <= {and1, nand1, or1, nor1, xor1, xnor1, not1};
      if (start) begin
        run_cnt         <= '0;
        timeout         <= 1'b0;
        mismatch        <= 1'b0;
        err_cnt         <= '0;
        vec_cnt         <= '0;
        cov             <= '0;
        first_fail_vld  <= 1'b0;
        first_fail_vec  <= '0;
        first_fail_mask <= '0;
      end else begin
        mismatch <= cmp_fail;
        if (state == RUN) begin
          run_cnt <= run_cnt + TW'(1);
          if (expire && !covered) timeout <= 1'b1;
        end
        if (s1_vld) begin
          cov <= cov_nxt;
          if (vec_cnt != '1) vec_cnt <= vec_cnt + ERR_W'(1);
          if (cmp_fail && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
          if (cmp_fail && !first_fail_vld) begin
            first_fail_vld  <= 1'b1;
            first_fail_vec  <= {s1_a, s1_b};
            first_fail_mask <= mask;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gates_checker.sv
// Directed self-checking bench for gates_checker: three instances cover the
// default build, a narrow-counter build (ERR_W=2) and a short timeout (TIMEOUT=8).
module tb_gates_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [6:0] obs = '0;

  logic       d_busy, d_done, d_pass, d_timeout, d_mismatch, d_ffv;
  logic [7:0] d_err, d_vec;
  logic [3:0] d_cov;
  logic [1:0] d_ffvec;
  logic [6:0] d_ffmask;

  logic       s_busy, s_done, s_pass, s_timeout, s_mismatch, s_ffv;
  logic [1:0] s_err, s_vec;
  logic [3:0] s_cov;
  logic [1:0] s_ffvec;
  logic [6:0] s_ffmask;

  logic       t_busy, t_done, t_pass, t_timeout, t_mismatch, t_ffv;
  logic [7:0] t_err, t_vec;
  logic [3:0] t_cov;
  logic [1:0] t_ffvec;
  logic [6:0] t_ffmask;

  int n_chk = 0;
  int n_fail = 0;
  int d_mm = 0;
  int s_mm = 0;
  int t_mm = 0;

  always #5 clk = ~clk;

  gates_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .and1(obs[6]), .nand1(obs[5]), .or1(obs[4]), .nor1(obs[3]),
    .xor1(obs[2]), .xnor1(obs[1]), .not1(obs[0]),
    .busy(d_busy), .done(d_done), .pass(d_pass), .timeout(d_timeout),
    .mismatch(d_mismatch), .err_cnt(d_err), .vec_cnt(d_vec), .cov(d_cov),
    .first_fail_vld(d_ffv), .first_fail_vec(d_ffvec), .first_fail_mask(d_ffmask)
  );

  gates_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .and1(obs[6]), .nand1(obs[5]), .or1(obs[4]), .nor1(obs[3]),
    .xor1(obs[2]), .xnor1(obs[1]), .not1(obs[0]),
    .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout),
    .mismatch(s_mismatch), .err_cnt(s_err), .vec_cnt(s_vec), .cov(s_cov),
    .first_fail_vld(s_ffv), .first_fail_vec(s_ffvec), .first_fail_mask(s_ffmask)
  );

  gates_checker #(.TIMEOUT(8)) u_to (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .and1(obs[6]), .nand1(obs[5]), .or1(obs[4]), .nor1(obs[3]),
    .xor1(obs[2]), .xnor1(obs[1]), .not1(obs[0]),
    .busy(t_busy), .done(t_done), .pass(t_pass), .timeout(t_timeout),
    .mismatch(t_mismatch), .err_cnt(t_err), .vec_cnt(t_vec), .cov(t_cov),
    .first_fail_vld(t_ffv), .first_fail_vec(t_ffvec), .first_fail_mask(t_ffmask)
  );

  // Advance one cycle; outputs are read 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    d_mm += int'(d_mismatch);
    s_mm += int'(s_mismatch);
    t_mm += int'(t_mismatch);
  endtask

  // Drive a valid vector; flt flips observed outputs away from the truth table.
  task automatic drive(input logic va, input logic vb, input logic [6:0] flt);
    logic [6:0] g;
    g = {va & vb, ~(va & vb), va | vb, ~(va | vb), va ^ vb, ~(va ^ vb), ~va};
    in_valid = 1'b1;
    a = va;
    b = vb;
    obs = g ^ flt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    d_mm = 0; s_mm = 0; t_mm = 0;
    tick();
    start = 1'b0;
  endtask

  // start at cycle 0, vectors 00,01,10,11 in cycles 2..5; returns in cycle 6.
  task automatic run_sweep(input logic [6:0] flt10);
    pulse_start();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      drive(ab[1], ab[0], (i == 2) ? flt10 : 7'b0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({d_busy, d_done, d_pass, d_timeout, d_mismatch, d_err, d_vec, d_cov,
         d_ffv, d_ffvec, d_ffmask} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%0d vec=%0d cov=%b, required all 0",
               d_busy, d_done, d_err, d_vec, d_cov);
    end
    n_chk++;
    if ({t_busy, t_done, t_timeout, t_vec, t_cov} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_to: busy=%b done=%b timeout=%b, required all 0",
               t_busy, t_done, t_timeout);
    end
  endtask

  task automatic test_all_pass();
    run_sweep(7'b0);
    n_chk++;
    if (d_done !== 1'b0 || d_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_done_early: done=%b busy=%b, required done=0 busy=1 at cycle 6", d_done, d_busy);
    end
    tick();
    n_chk++;
    if (d_done !== 1'b1 || d_pass !== 1'b1 || d_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_done: done=%b pass=%b busy=%b, required 1 1 0", d_done, d_pass, d_busy);
    end
    n_chk++;
    if (d_err !== 8'd0 || d_vec !== 8'd4 || d_cov !== 4'b1111 || d_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_counts: err=%0d vec=%0d cov=%b timeout=%b, required 0 4 1111 0",
               d_err, d_vec, d_cov, d_timeout);
    end
    n_chk++;
    if (d_mm !== 0 || d_ffv !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_no_mismatch: pulses=%0d ffv=%b, required 0 0", d_mm, d_ffv);
    end
  endtask

  task automatic test_first_fail();
    run_sweep(7'b0000100);
    tick();
    n_chk++;
    if (d_done !== 1'b1 || d_pass !== 1'b0 || d_err !== 8'd1 || d_mm !== 1) begin
      n_fail++;
      $display("FAIL ff_status: done=%b pass=%b err=%0d pulses=%0d, required 1 0 1 1",
               d_done, d_pass, d_err, d_mm);
    end
    n_chk++;
    if (d_ffv !== 1'b1 || d_ffvec !== 2'b10 || d_ffmask !== 7'b0000100) begin
      n_fail++;
      $display("FAIL ff_capture: vld=%b vec=%b mask=%b, required 1 10 0000100",
               d_ffv, d_ffvec, d_ffmask);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    drive(1'b0, 1'b0, 7'b0);
    repeat (3) tick();
    n_chk++;
    if (t_vec !== 8'd2) begin
      n_fail++;
      $display("FAIL to_vec_count: vec=%0d, required 2 at cycle 4", t_vec);
    end
    repeat (4) tick();
    n_chk++;
    if (t_done !== 1'b0 || t_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_early: done=%b timeout=%b, required 0 0 at cycle 8", t_done, t_timeout);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (t_done !== 1'b1 || t_timeout !== 1'b1 || t_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fire: done=%b timeout=%b pass=%b, required 1 1 0", t_done, t_timeout, t_pass);
    end
    n_chk++;
    if (t_cov !== 4'b0001 || t_vec !== 8'd7) begin
      n_fail++;
      $display("FAIL to_counts: cov=%b vec=%0d, required 0001 7", t_cov, t_vec);
    end
    repeat (2) tick();
    n_chk++;
    if (t_done !== 1'b1 || t_vec !== 8'd7) begin
      n_fail++;
      $display("FAIL to_hold: done=%b vec=%0d, required 1 7", t_done, t_vec);
    end
  endtask

  task automatic test_saturation();
    pulse_start();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 7'b1000000);
      tick();
    end
    drive(1'b0, 1'b1, 7'b0); tick();
    drive(1'b1, 1'b0, 7'b0); tick();
    drive(1'b1, 1'b1, 7'b0); tick();
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (s_err !== 2'd3 || s_vec !== 2'd3 || s_mm !== 5) begin
      n_fail++;
      $display("FAIL sat_counts: err=%0d vec=%0d pulses=%0d, required 3 3 5", s_err, s_vec, s_mm);
    end
    n_chk++;
    if (s_done !== 1'b1 || s_pass !== 1'b0 || s_cov !== 4'b1111) begin
      n_fail++;
      $display("FAIL sat_done: done=%b pass=%b cov=%b, required 1 0 1111", s_done, s_pass, s_cov);
    end
    n_chk++;
    if (s_ffvec !== 2'b00 || s_ffmask !== 7'b1000000) begin
      n_fail++;
      $display("FAIL sat_first: vec=%b mask=%b, required 00 1000000", s_ffvec, s_ffmask);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    drive(1'b0, 1'b0, 7'b1000000);
    tick();
    drive(1'b0, 1'b0, 7'b1000000);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    n_chk++;
    if (d_err !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_pre_err: err=%0d, required 1 before reset", d_err);
    end
    tick();
    rst = 1'b0;
    n_chk++;
    if ({d_busy, d_done, d_pass, d_timeout, d_mismatch, d_err, d_vec, d_cov,
         d_ffv, d_ffvec, d_ffmask} !== '0) begin
      n_fail++;
      $display("FAIL rst_midrun: busy=%b mismatch=%b err=%0d vec=%0d ffv=%b, required all 0",
               d_busy, d_mismatch, d_err, d_vec, d_ffv);
    end
    repeat (3) tick();
    n_chk++;
    if (d_busy !== 1'b0 || d_vec !== 8'd0 || d_err !== 8'd0 || d_mm !== 1) begin
      n_fail++;
      $display("FAIL rst_inflight: busy=%b vec=%0d err=%0d pulses=%0d, required 0 0 0 1",
               d_busy, d_vec, d_err, d_mm);
    end
  endtask

  task automatic test_start_collision();
    drive(1'b0, 1'b0, 7'b0);
    pulse_start();
    drive(1'b0, 1'b1, 7'b0);
    tick();
    drive(1'b1, 1'b0, 7'b0);
    tick();
    n_chk++;
    if (d_vec !== 8'd1 || d_cov !== 4'b0010) begin
      n_fail++;
      $display("FAIL start_same_cycle: vec=%0d cov=%b, required 1 0010", d_vec, d_cov);
    end
    start = 1'b1;
    drive(1'b1, 1'b1, 7'b0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    n_chk++;
    if (d_vec !== 8'd0 || d_cov !== 4'b0000 || d_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_midrun: vec=%0d cov=%b busy=%b, required 0 0000 1", d_vec, d_cov, d_busy);
    end
    repeat (2) tick();
    n_chk++;
    if (d_vec !== 8'd0 || d_cov !== 4'b0000) begin
      n_fail++;
      $display("FAIL start_drop: vec=%0d cov=%b, required 0 0000", d_vec, d_cov);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_first_fail();
    test_timeout();
    test_saturation();
    test_reset_midrun();
    test_start_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
